// File: rtl/fm_pkg.sv
// fm_pkg: shared types and constants for the frame-memory writer/reader pair.
package fm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fm_state_e;

  localparam int NUM_BANKS  = 3;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 11;

  // One-hot bank select for the line-RAM write enables.
  function automatic logic [NUM_BANKS-1:0] bank_onehot(input logic [1:0] bank);
    return NUM_BANKS'(1) << bank;
  endfunction

endpackage

// File: rtl/fm_write_if.sv
// fm_write_if: upstream pixel stream plus line-RAM write port of fm_write.
interface fm_write_if
  import fm_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) ();
  logic                 s_valid;
  logic [DATA_W-1:0]    s_data;
  logic                 s_ready;
  logic [NUM_BANKS-1:0] ram_wen;
  logic [ADDR_W-1:0]    ram_waddr;
  logic [DATA_W-1:0]    ram_wdata;

  // Writer side: consumes the stream, drives the RAM port.
  modport slave (
    input  s_valid, s_data,
    output s_ready, ram_wen, ram_waddr, ram_wdata
  );

  // Source / RAM side.
  modport master (
    output s_valid, s_data,
    input  s_ready, ram_wen, ram_waddr, ram_wdata
  );
endinterface

// File: rtl/fm_bank_ctr.sv
// fm_bank_ctr: count of complete, unreleased line-RAM rows (0..3).
module fm_bank_ctr (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  input  logic       dec,
  output logic [1:0] count
);
  logic [1:0] count_q, count_d;

  // Next count: clear wins; simultaneous inc/dec cancel; saturate at 0 and 3.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = 2'd0;
    end else if (inc && !dec) begin
      if (count_q != 2'd3) count_d = count_q + 2'd1;
    end else if (dec && !inc) begin
      if (count_q != 2'd0) count_d = count_q - 2'd1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= 2'd0;
    else     count_q <= count_d;
  end

  assign count = count_q;
endmodule

// File: rtl/fm_write.sv
// fm_write: writes a raster pixel stream into three rotating line-RAM banks.
// Optional macro FM_WRITE_STATS_EN enables the saturating stall-cycle counter.
module fm_write
  import fm_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        module_en,
  input  logic [8:0]  fm_width,
  input  logic [8:0]  fm_height,
  input  logic        row_release,
  output logic [1:0]  rows_avail,
  output logic        refresh,
  output logic        frame_done,
  output logic [15:0] stall_cnt,
  fm_write_if.slave   bus
);
  fm_state_e            state_q, state_d;
  logic [ADDR_W-1:0]    col_q;
  logic [8:0]           row_q;
  logic [1:0]           wr_bank_q;
  logic [8:0]           width_q, height_q;
  logic [NUM_BANKS-1:0] ram_wen_q;
  logic [ADDR_W-1:0]    ram_waddr_q;
  logic [DATA_W-1:0]    ram_wdata_q;
  logic                 refresh_q, frame_done_q;

  logic s_ready_c, accept, start, abort, last_col, last_row, row_done;

  assign last_col = (col_q == ADDR_W'(width_q) - ADDR_W'(1));
  assign last_row = (row_q == height_q - 9'd1);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; DONE must pass through IDLE before a new frame.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (module_en && fm_width >= 9'd3 && fm_height >= 9'd3) state_d = FILL;
      FILL: begin
        if (!module_en)              state_d = IDLE;
        else if (row_done && last_row) state_d = DONE;
      end
      DONE: if (!module_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; ready comes only from registers, and a pixel offered while
  // module_en is low is not taken even though ready may still read high.
  always_comb begin
    s_ready_c = (state_q == FILL) && (rows_avail != 2'd3);
    start     = (state_q == IDLE) && module_en && (fm_width >= 9'd3) && (fm_height >= 9'd3);
    abort     = (state_q == FILL) && !module_en;
    accept    = bus.s_valid && s_ready_c && module_en;
    row_done  = accept && last_col;
  end

  // Write datapath: column/row/bank tracking and registered RAM port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      wr_bank_q    <= '0;
      width_q      <= '0;
      height_q     <= '0;
      ram_wen_q    <= '0;
      ram_waddr_q  <= '0;
      ram_wdata_q  <= '0;
      refresh_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      ram_wen_q    <= '0;
      refresh_q    <= 1'b0;
      frame_done_q <= 1'b0;
      if (start) begin
        col_q     <= '0;
        row_q     <= '0;
        wr_bank_q <= '0;
        width_q   <= fm_width;
        height_q  <= fm_height;
      end else if (abort) begin
        col_q     <= '0;
        row_q     <= '0;
        wr_bank_q <= '0;
      end else if (accept) begin
        ram_wen_q   <= bank_onehot(wr_bank_q);
        ram_waddr_q <= col_q;
        ram_wdata_q <= bus.s_data;
        if (last_col) begin
          col_q        <= '0;
          wr_bank_q    <= (wr_bank_q == 2'(NUM_BANKS - 1)) ? 2'd0 : wr_bank_q + 2'd1;
          row_q        <= row_q + 9'd1;
          refresh_q    <= 1'b1;
          frame_done_q <= last_row;
        end else begin
          col_q <= col_q + ADDR_W'(1);
        end
      end
    end
  end

  fm_bank_ctr u_bank_ctr (
    .clk   (clk),
    .rst   (rst),
    .clr   (start || abort),
    .inc   (row_done),
    .dec   (row_release),
    .count (rows_avail)
  );

`ifdef FM_WRITE_STATS_EN
  logic [15:0] stall_q;

  // Stall counter: FILL cycles where a pixel waits on a full bank set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= 16'd0;
    end else if (start) begin
      stall_q <= 16'd0;
    end else if ((state_q == FILL) && bus.s_valid && !s_ready_c && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 16'd0;
`endif

  assign bus.s_ready   = s_ready_c;
  assign bus.ram_wen   = ram_wen_q;
  assign bus.ram_waddr = ram_waddr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign refresh       = refresh_q;
  assign frame_done    = frame_done_q;
endmodule

// File: tb/tb_fm_write.sv
// tb_fm_write: directed, table-driven checks of fm_write.
module tb_fm_write;
  logic        clk;
  logic        rst;
  logic        module_en;
  logic [8:0]  fm_width;
  logic [8:0]  fm_height;
  logic        row_release;
  logic [1:0]  rows_avail;
  logic        refresh;
  logic        frame_done;
  logic [15:0] stall_cnt;

  fm_write_if #(.DATA_W(8), .ADDR_W(11)) bus ();

  fm_write dut (
    .clk         (clk),
    .rst         (rst),
    .module_en   (module_en),
    .fm_width    (fm_width),
    .fm_height   (fm_height),
    .row_release (row_release),
    .rows_avail  (rows_avail),
    .refresh     (refresh),
    .frame_done  (frame_done),
    .stall_cnt   (stall_cnt),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0]  data;
    logic [2:0]  wen;
    logic [10:0] addr;
    logic        rfs;
    logic        done;
    logic [1:0]  rows;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepted;
    logic [15:0] exp_stall;

    vecs[0]  = '{8'hA0, 3'b001, 11'd0, 1'b0, 1'b0, 2'd0};
    vecs[1]  = '{8'hA1, 3'b001, 11'd1, 1'b0, 1'b0, 2'd0};
    vecs[2]  = '{8'hA2, 3'b001, 11'd2, 1'b0, 1'b0, 2'd0};
    vecs[3]  = '{8'hA3, 3'b001, 11'd3, 1'b1, 1'b0, 2'd1};
    vecs[4]  = '{8'hA4, 3'b010, 11'd0, 1'b0, 1'b0, 2'd1};
    vecs[5]  = '{8'hA5, 3'b010, 11'd1, 1'b0, 1'b0, 2'd1};
    vecs[6]  = '{8'hA6, 3'b010, 11'd2, 1'b0, 1'b0, 2'd1};
    vecs[7]  = '{8'hA7, 3'b010, 11'd3, 1'b1, 1'b0, 2'd2};
    vecs[8]  = '{8'hA8, 3'b100, 11'd0, 1'b0, 1'b0, 2'd2};
    vecs[9]  = '{8'hA9, 3'b100, 11'd1, 1'b0, 1'b0, 2'd2};
    vecs[10] = '{8'hAA, 3'b100, 11'd2, 1'b0, 1'b0, 2'd2};
    vecs[11] = '{8'hAB, 3'b100, 11'd3, 1'b1, 1'b1, 2'd3};

`ifdef FM_WRITE_STATS_EN
    exp_stall = 16'd7;
`else
    exp_stall = 16'd0;
`endif

    rst = 1'b1; module_en = 1'b0; fm_width = 9'd0; fm_height = 9'd0;
    row_release = 1'b0; bus.s_valid = 1'b0; bus.s_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(bus.s_ready), 32'd0);
    chk("rst_wen", 32'(bus.ram_wen), 32'd0);
    chk("rst_rows", 32'(rows_avail), 32'd0);
    chk("rst_stall", 32'(stall_cnt), 32'd0);
    rst = 1'b0;
    tick();

    // Frame 4x3, continuous valid.
    module_en = 1'b1; fm_width = 9'd4; fm_height = 9'd3;
    tick();
    for (int k = 0; k < 12; k++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = vecs[k].data;
      chk("f1_ready", 32'(bus.s_ready), 32'd1);
      tick();
      $display("[TB] f1 px %0d wen=%b addr=%0d data=%h rfs=%b done=%b rows=%0d",
               k, bus.ram_wen, bus.ram_waddr, bus.ram_wdata, refresh, frame_done, rows_avail);
      chk("f1_wen", 32'(bus.ram_wen), 32'(vecs[k].wen));
      chk("f1_addr", 32'(bus.ram_waddr), 32'(vecs[k].addr));
      chk("f1_data", 32'(bus.ram_wdata), 32'(vecs[k].data));
      chk("f1_refresh", 32'(refresh), 32'(vecs[k].rfs));
      chk("f1_done", 32'(frame_done), 32'(vecs[k].done));
      chk("f1_rows", 32'(rows_avail), 32'(vecs[k].rows));
    end
    chk("f1_done_ready", 32'(bus.s_ready), 32'd0);
    tick();
    chk("f1_done_nowen", 32'(bus.ram_wen), 32'd0);
    chk("f1_done_pulse", 32'(frame_done), 32'd0);
    tick();
    chk("f1_no_refill", 32'(bus.s_ready), 32'd0);
    module_en = 1'b0; bus.s_valid = 1'b0;
    tick();
    $display("[TB] frame1 complete, back to idle");

    // Frame 3x5 without release: backpressure after three rows.
    module_en = 1'b1; fm_width = 9'd3; fm_height = 9'd5;
    tick();
    accepted = 0;
    for (int c = 0; c < 20 && accepted < 9; c++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 8'(c);
      if (bus.s_ready) accepted++;
      tick();
    end
    $display("[TB] f2 accepted %0d pixels, rows=%0d", accepted, rows_avail);
    chk("f2_accepted", 32'(accepted), 32'd9);
    chk("f2_rows_full", 32'(rows_avail), 32'd3);
    for (int c = 0; c < 7; c++) begin
      chk("f2_stalled", 32'(bus.s_ready), 32'd0);
      tick();
      chk("f2_stall_nowen", 32'(bus.ram_wen), 32'd0);
    end
    $display("[TB] f2 stall_cnt=%0d", stall_cnt);
    chk("f2_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
    row_release = 1'b1;
    tick();
    row_release = 1'b0;
    chk("f2_rel_rows", 32'(rows_avail), 32'd2);
    chk("f2_rel_ready", 32'(bus.s_ready), 32'd1);
    for (int j = 0; j < 3; j++) begin
      bus.s_data  = 8'h30 + 8'(j);
      row_release = (j == 2);
      tick();
      $display("[TB] f2 row3 px %0d wen=%b addr=%0d rows=%0d", j, bus.ram_wen, bus.ram_waddr, rows_avail);
      chk("f2_r3_wen", 32'(bus.ram_wen), 32'b001);
      chk("f2_r3_addr", 32'(bus.ram_waddr), 32'(j));
    end
    row_release = 1'b0;
    chk("f2_simul_rows", 32'(rows_avail), 32'd2);
    chk("f2_simul_refresh", 32'(refresh), 32'd1);
    for (int j = 0; j < 3; j++) begin
      bus.s_data = 8'h40 + 8'(j);
      tick();
      $display("[TB] f2 row4 px %0d wen=%b addr=%0d done=%b", j, bus.ram_wen, bus.ram_waddr, frame_done);
      chk("f2_r4_wen", 32'(bus.ram_wen), 32'b010);
      chk("f2_r4_done", 32'(frame_done), (j == 2) ? 32'd1 : 32'd0);
    end
    bus.s_valid = 1'b0;
    chk("f2_end_rows", 32'(rows_avail), 32'd3);
    row_release = 1'b1;
    for (int r = 0; r < 4; r++) begin
      tick();
      $display("[TB] f2 release %0d rows=%0d", r, rows_avail);
      chk("f2_drain_rows", 32'(rows_avail), (r < 3) ? 32'(2 - r) : 32'd0);
    end
    row_release = 1'b0;
    module_en = 1'b0;
    tick();

    // Abort after 5 pixels, then restart.
    module_en = 1'b1; fm_width = 9'd4; fm_height = 9'd3;
    tick();
    bus.s_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.s_data = 8'h50 + 8'(k);
      tick();
    end
    chk("ab_px5_wen", 32'(bus.ram_wen), 32'b010);
    chk("ab_rows_before", 32'(rows_avail), 32'd1);
    module_en = 1'b0;
    bus.s_data = 8'h5F;
    tick();
    $display("[TB] abort wen=%b ready=%b rows=%0d", bus.ram_wen, bus.s_ready, rows_avail);
    chk("ab_nowen", 32'(bus.ram_wen), 32'd0);
    chk("ab_ready", 32'(bus.s_ready), 32'd0);
    chk("ab_rows", 32'(rows_avail), 32'd0);
    tick();
    chk("ab_idle_nowen", 32'(bus.ram_wen), 32'd0);
    module_en = 1'b1;
    tick();
    bus.s_data = 8'h55;
    tick();
    $display("[TB] restart wen=%b addr=%0d data=%h", bus.ram_wen, bus.ram_waddr, bus.ram_wdata);
    chk("re_wen", 32'(bus.ram_wen), 32'b001);
    chk("re_addr", 32'(bus.ram_waddr), 32'd0);
    chk("re_data", 32'(bus.ram_wdata), 32'h55);
    bus.s_data = 8'h66;
    tick();
    chk("re_addr1", 32'(bus.ram_waddr), 32'd1);

    // Asynchronous reset mid-row.
    #3;
    rst = 1'b1;
    #1;
    $display("[TB] async rst wen=%b addr=%0d data=%h ready=%b", bus.ram_wen, bus.ram_waddr, bus.ram_wdata, bus.s_ready);
    chk("ar_wen", 32'(bus.ram_wen), 32'd0);
    chk("ar_addr", 32'(bus.ram_waddr), 32'd0);
    chk("ar_data", 32'(bus.ram_wdata), 32'd0);
    chk("ar_ready", 32'(bus.s_ready), 32'd0);
    chk("ar_refresh", 32'(refresh), 32'd0);
    chk("ar_done", 32'(frame_done), 32'd0);
    chk("ar_rows", 32'(rows_avail), 32'd0);
    chk("ar_stall", 32'(stall_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    fm_width = 9'd2; fm_height = 9'd3; module_en = 1'b1; bus.s_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("w2_ready", 32'(bus.s_ready), 32'd0);
      chk("w2_nowen", 32'(bus.ram_wen), 32'd0);
    end
    $display("[TB] width2 stays idle ready=%b", bus.s_ready);
    bus.s_valid = 1'b0;
    module_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
